// File: rtl/display_scan_controller.sv
// display_scan_controller
// Multiplexed scan sequencer for four common-anode seven-segment digits.
// Each digit slot opens with an all-off dead-time to suppress ghosting, then
// lights the selected anode for a brightness-dependent share of the slot,
// then stays off for the remainder. A double-buffered value register is loaded
// through a valid/ready handshake. The new value is committed only at the end
// of a full frame, so one frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module display_scan_controller #(
    parameter int TICKS_PER_DIGIT = 12500,
    parameter int BLANK_TICKS     = 16,
    parameter int CNT_W           = 14
) (
    input  logic        frecuenciaReloj,
    input  logic        reset_n,
    input  logic [15:0] valor,
    input  logic        cargar,
    output logic        listo,
    input  logic [3:0]  mascara,
    input  logic [3:0]  brillo,
    output logic [3:0]  anodos,
    output logic [3:0]  digito,
    output logic [1:0]  selector,
    output logic        finDeBarrido
);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_ON,
        ST_OFF
    } state_t;

    localparam int              ACTIVE_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;
    localparam int              PROD_W       = CNT_W + 5;
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_TICKS - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               slot_start;
    logic               slot_end;
    logic [CNT_W-1:0]   on_last_q;
    logic [3:0]         mask_q;
    logic [15:0]        display_reg;
    logic [15:0]        pending_reg;
    logic               transfer;
    logic               commit;

    logic [PROD_W-1:0]  on_product;
    logic [PROD_W-1:0]  on_last_wide;
    logic [CNT_W-1:0]   on_last;
    logic [3:0]         auto_en;
    logic [15:0]        digit_src;
    logic [1:0]         next_sel;
    logic [3:0]         next_digit;

    assign slot_start   = (cnt == '0);
    assign slot_end     = (cnt == LAST_CNT);
    assign finDeBarrido = (selector == 2'd3) && slot_end;
    assign transfer     = cargar && listo;
    assign commit       = finDeBarrido && !listo;

    // Lit time scales with brillo+1 in sixteenths of the post-dead-time window;
    // the product is formed at full width before the shift so nothing truncates.
    // on_last is the slot cycle index of the final lit cycle.
    assign on_product   = PROD_W'(ACTIVE_TICKS) * PROD_W'({1'b0, brillo} + 5'd1);
    assign on_last_wide = (on_product >> 4) + PROD_W'(BLANK_TICKS - 1);
    assign on_last      = CNT_W'(on_last_wide);

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is shown only if it or some higher digit is nonzero. Digit 0 always shows.
    assign auto_en = {|display_reg[15:12], |display_reg[15:8], |display_reg[15:4], 1'b1};
`else
    assign auto_en = 4'hF;
`endif

    // The next slot's digit comes from the value committed at this very edge, so
    // slot 0 of the new frame already shows a freshly loaded value.
    assign digit_src  = commit ? pending_reg : display_reg;
    assign next_sel   = selector + 2'd1;
    assign next_digit = 4'(digit_src >> {next_sel, 2'b00});

    // Slot counter, digit selector and the digit nibble all advance together at slot wrap.
    always_ff @(posedge frecuenciaReloj or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            selector <= 2'd0;
            digito   <= 4'd0;
        end else if (slot_end) begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values and the evaluation order of blocks doesn't matter.
            cnt      <= '0;
            selector <= next_sel;
            digito   <= next_digit;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    // Brightness and enables are frozen for the whole slot at its first cycle.
    always_ff @(posedge frecuenciaReloj or negedge reset_n) begin
        if (!reset_n) begin
            on_last_q <= '0;
            mask_q    <= 4'd0;
        end else if (slot_start) begin
            on_last_q <= on_last;
            mask_q    <= mascara & auto_en;
        end
    end

    // Double-buffer handshake: capture into pending, commit to display at frame end.
    always_ff @(posedge frecuenciaReloj or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= 16'd0;
            display_reg <= 16'd0;
            listo       <= 1'b1;
        end else if (transfer) begin
            pending_reg <= valor;
            listo       <= 1'b0;
        end else if (commit) begin
            display_reg <= pending_reg;
            listo       <= 1'b1;
        end
    end

    // Slot phase state register.
    always_ff @(posedge frecuenciaReloj or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_BLANK;
        end else begin
            state <= state_next;
        end
    end

    // Phase sequencing BLANK -> ON -> OFF and anode drive for the current phase.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves a variable unassigned, which would infer a latch.
        state_next = state;
        anodos     = 4'b1111;
        unique case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (mask_q[selector]) begin
                    anodos[selector] = 1'b0;
                end
                if (slot_end) begin
                    state_next = ST_BLANK;
                end else if (cnt == on_last_q) begin
                    state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if (slot_end) begin
                    state_next = ST_BLANK;
                end
            end
            default: begin
                state_next = ST_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (short slots: 32 cycles, 4 dead).
// A cycle-indexed reference model derives each cycle's expected outputs from
// slot arithmetic and the handshake rules; expectations are queued by the
// driver and popped by an independent monitor on the falling clock edge.
module tb_display_scan_controller;

    localparam int TPD    = 32;
    localparam int BLK    = 4;
    localparam int ACTIVE = TPD - BLK;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] valor = 16'd0;
    logic        cargar = 1'b0;
    logic [3:0]  mascara = 4'd0;
    logic [3:0]  brillo = 4'd0;
    logic        listo;
    logic [3:0]  anodos;
    logic [3:0]  digito;
    logic [1:0]  selector;
    logic        finDeBarrido;

    always #5 clk = ~clk;

    display_scan_controller #(
        .TICKS_PER_DIGIT(TPD),
        .BLANK_TICKS    (BLK),
        .CNT_W          (14)
    ) dut (
        .frecuenciaReloj(clk),
        .reset_n        (reset_n),
        .valor          (valor),
        .cargar         (cargar),
        .listo          (listo),
        .mascara        (mascara),
        .brillo         (brillo),
        .anodos         (anodos),
        .digito         (digito),
        .selector       (selector),
        .finDeBarrido   (finDeBarrido)
    );

    typedef struct packed {
        logic [3:0] anodos;
        logic [1:0] selector;
        logic [3:0] digito;
        logic       listo;
        logic       fin;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int          cyc = 0;
    logic [15:0] m_display = 16'd0;
    logic [15:0] m_pending = 16'd0;
    bit          m_listo = 1'b1;
    int          slot_on = 0;
    logic [3:0]  slot_m = 4'd0;
    logic [3:0]  slot_digit = 4'd0;

    // Stimulus controls
    int          force_b = -1;
    int          force_m = -1;
    int          load_pct = 0;
    bit          want_load = 1'b0;
    logic [15:0] want_val = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, want, $time);
        end
    endtask

    function automatic logic [3:0] lz_enable(input logic [15:0] d);
        logic [3:0] en;
        en = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 4; i++) begin
            en[i] = ((d >> (4 * i)) != 16'd0);
        end
`endif
        return en;
    endfunction

    // Monitor: compare every out-of-reset cycle against the queued expectation.
    always @(negedge clk) begin
        if (reset_n && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("anodos", {28'd0, anodos}, {28'd0, mon_e.anodos});
            check("selector", {30'd0, selector}, {30'd0, mon_e.selector});
            check("digito", {28'd0, digito}, {28'd0, mon_e.digito});
            check("listo", {31'd0, listo}, {31'd0, mon_e.listo});
            check("finDeBarrido", {31'd0, finDeBarrido}, {31'd0, mon_e.fin});
        end
    end

    // One model cycle: queue expected outputs, drive inputs, advance the model.
    // Entered and left 1 time unit after a rising edge.
    task automatic step();
        int          off;
        int          sel;
        int          b;
        int          m;
        bit          ld;
        bit          lit;
        bit          fin;
        logic [15:0] v;
        exp_t        e;
        off = cyc % TPD;
        sel = (cyc / TPD) % 4;
        if (off == 0) begin
            slot_digit = 4'(m_display >> (4 * sel));
        end
        lit = (off >= BLK) && (off < BLK + slot_on) && slot_m[sel];
        fin = (sel == 3) && (off == TPD - 1);
        e.anodos   = lit ? ~(4'b0001 << sel) : 4'b1111;
        e.selector = 2'(sel);
        e.digito   = slot_digit;
        e.listo    = m_listo;
        e.fin      = fin;
        exp_q.push_back(e);

        b  = (force_b < 0) ? int'($urandom_range(15)) : force_b;
        m  = (force_m < 0) ? int'($urandom_range(15)) : force_m;
        v  = 16'($urandom);
        ld = 1'b0;
        if (want_load) begin
            ld        = 1'b1;
            v         = want_val;
            want_load = 1'b0;
        end else if (load_pct > 0 && int'($urandom_range(99)) < load_pct) begin
            ld = 1'b1;
        end
        brillo  = 4'(b);
        mascara = 4'(m);
        cargar  = ld;
        valor   = v;

        if (off == 0) begin
            slot_on = (ACTIVE * (b + 1)) / 16;
            slot_m  = 4'(m) & lz_enable(m_display);
        end
        if (ld && m_listo) begin
            m_pending = v;
            m_listo   = 1'b0;
        end else if (fin && !m_listo) begin
            m_display = m_pending;
            m_listo   = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int s, input int o);
        for (int i = 0; i < 4 * TPD; i++) begin
            if ((cyc % TPD) == o && ((cyc / TPD) % 4) == s) break;
            step();
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must return to reset values at once.
    task automatic apply_reset();
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        cargar    = 1'b0;
        want_load = 1'b0;
        cyc       = 0;
        m_display = 16'd0;
        m_pending = 16'd0;
        m_listo   = 1'b1;
        #1;
        check("rst_anodos", {28'd0, anodos}, 32'hF);
        check("rst_selector", {30'd0, selector}, 32'd0);
        check("rst_digito", {28'd0, digito}, 32'd0);
        check("rst_listo", {31'd0, listo}, 32'd1);
        check("rst_fin", {31'd0, finDeBarrido}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        apply_reset();

        // Fixed brightness levels at full enable
        force_m = 15;
        force_b = 15; run_cycles(4 * TPD);
        force_b = 0;  run_cycles(4 * TPD);
        force_b = 7;  run_cycles(4 * TPD);

        // Mid-frame load, then a second offer while busy
        force_b = 15;
        run_until(2, 0);
        want_load = 1'b1; want_val = 16'hA5C3;
        run_cycles(3);
        want_load = 1'b1; want_val = 16'h1234;
        run_cycles(8 * TPD);

        // Partial mask with brightness changing every cycle
        force_m = 5;
        force_b = -1;
        run_cycles(8 * TPD);

        // Leading zeros
        force_m = 15;
        force_b = 15;
        run_until(0, 5);
        want_load = 1'b1; want_val = 16'h0070;
        run_cycles(12 * TPD);

        // Fully random traffic
        force_b  = -1;
        force_m  = -1;
        load_pct = 5;
        run_cycles(80 * TPD);

        // Reset during ON of slot 2 with a load still pending
        load_pct = 0;
        force_b  = 15;
        force_m  = 15;
        run_until(1, 3);
        want_load = 1'b1; want_val = 16'hBEEF;
        step();
        run_until(2, 10);
        check("pre_reset_on", {28'd0, anodos}, 32'hB);
        check("pre_reset_busy", {31'd0, listo}, 32'd0);
        apply_reset();
        run_cycles(8 * TPD);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
